// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Default geometry is the 640x480@60 mode with a 25.175 MHz-class pixel clock.
package vga_timing_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;

    localparam bit SYNC_POS = 1'b1;
    localparam bit SYNC_NEG = 1'b0;

    function automatic int H_TOTAL(int disp, int fp, int sw, int bp);
        return disp + fp + sw + bp;
    endfunction

    function automatic int V_TOTAL(int disp, int bot, int sw, int top);
        return disp + bot + sw + top;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-clock divider: tick is high on the last clk cycle of each pixel.
// Resets to the terminal count so the first enabled cycle is a tick.
module vga_pix_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= LAST;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with aligned registered outputs.
// Define VGA_TIMING_VBLANK_FLAG_EN to build the sticky vblank_flag.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_BOTTOM   = DEF_V_BOTTOM,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_TOP      = DEF_V_TOP,
    parameter bit H_SYNC_POL = SYNC_POS,
    parameter bit V_SYNC_POL = SYNC_POS,
    parameter int CLK_DIV    = 1,
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int FCW        = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           vblank_ack,
    output logic           pix_ce,
    output logic [HW-1:0]  hpos,
    output logic [VW-1:0]  vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt,
    output logic           vblank_flag
);

    localparam int HT = H_TOTAL(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int VT = V_TOTAL(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] H_DISP = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
    localparam logic [VW-1:0] V_DISP = VW'(V_DISPLAY);
    localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_BOTTOM);
    localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic          tick;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          at_origin;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // Position the next tick will present; all outputs decode this value.
    always_comb begin
        h_nxt = hpos + 1'b1;
        v_nxt = vpos;
        if (hpos == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vpos == V_LAST) ? '0 : vpos + 1'b1;
        end
    end

    assign at_origin = (h_nxt == '0) && (v_nxt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
            pix_ce      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '1;
        end else begin
            pix_ce      <= tick;
            line_start  <= tick && (h_nxt == '0);
            frame_start <= tick && at_origin;
            if (tick) begin
                hpos       <= h_nxt;
                vpos       <= v_nxt;
                hsync      <= (h_nxt >= HS_BEG && h_nxt <= HS_END)
                              ? H_SYNC_POL : ~H_SYNC_POL;
                vsync      <= (v_nxt >= VS_BEG && v_nxt <= VS_END)
                              ? V_SYNC_POL : ~V_SYNC_POL;
                display_on <= (h_nxt < H_DISP) && (v_nxt < V_DISP);
                if (at_origin) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

`ifdef VGA_TIMING_VBLANK_FLAG_EN
    // Setting wins over a simultaneous ack so the event is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vblank_flag <= 1'b0;
        end else if (tick && h_nxt == '0 && v_nxt == V_DISP) begin
            vblank_flag <= 1'b1;
        end else if (vblank_ack) begin
            vblank_flag <= 1'b0;
        end
    end
`else
    logic unused_ack;
    assign unused_ack  = vblank_ack;
    assign vblank_flag = 1'b0;
`endif

endmodule
